// File: rtl/common_pkg.sv
// common_pkg: shared SPI SRAM command constants and memory-controller state types.
package common_pkg;
`ifdef MEM_CTRL_SRAM_INIT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, INIT} mem_state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} mem_state_t;
`endif
  typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE, OP_INIT} mem_op_t;
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_WRMR  = 8'h01;
  localparam logic [7:0] SPI_MODE_SEQ  = 8'h40;
endpackage

// File: rtl/spi_bit_engine.sv
// spi_bit_engine: mode-0 SPI shifter, two clocks per bit, MSB-first, MISO captured at the end of the SCK-high phase.
module spi_bit_engine #(
  parameter int TXW = 40,
  parameter int RXW = 16
) (
  input  logic           clk_in,
  input  logic           reset_n_in,
  input  logic           start,
  input  logic           en,
  input  logic [5:0]     len,
  input  logic [TXW-1:0] tx,
  input  logic           miso,
  output logic           sck,
  output logic           mosi,
  output logic           last,
  output logic [RXW-1:0] rx_next
);
  logic [TXW-1:0] tx_sh;
  logic [RXW-2:0] rx;
  logic [5:0]     cnt;
  logic           phase;
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      tx_sh <= '0;
      rx    <= '0;
      cnt   <= '0;
      phase <= 1'b0;
    end else if (start) begin
      tx_sh <= tx;
      cnt   <= len;
      phase <= 1'b0;
    end else if (en) begin
      phase <= ~phase;
      if (phase) begin
        tx_sh <= tx_sh << 1;
        rx    <= rx_next[RXW-2:0];
        cnt   <= cnt - 6'd1;
      end
    end
  assign sck     = en & phase;
  assign mosi    = en & tx_sh[TXW-1];
  assign last    = en & phase & (cnt == 6'd0);
  assign rx_next = {rx, miso};
endmodule

// File: rtl/mem_ctrl_spi.sv
// mem_ctrl_spi: serves fetch/load/store requests as SPI SRAM frames.
// Define MEM_CTRL_SRAM_INIT_EN to send a WRMR (sequential mode) frame after reset.
module mem_ctrl_spi
  import common_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int INST_BYTES = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    inst_fetch_req_in,
  input  logic                    data_read_req_in,
  input  logic                    data_write_req_in,
  input  logic [ADDR_WIDTH-1:0]   inst_addr_in,
  input  logic [ADDR_WIDTH-1:0]   data_addr_in,
  input  logic [7:0]              wdata_in,
  output logic                    mem_busy_out,
  output logic                    inst_fetch_done_out,
  output logic                    data_read_done_out,
  output logic [8*INST_BYTES-1:0] inst_out,
  output logic [7:0]              rdata_out,
  output logic                    spi_cs_n_out,
  output logic                    spi_sck_out,
  output logic                    spi_mosi_out,
  input  logic                    spi_miso_in
);
  localparam int DW  = 8 * INST_BYTES;
  localparam int TXW = 8 + ADDR_WIDTH + DW;
`ifdef MEM_CTRL_SRAM_INIT_EN
  localparam mem_state_t ST_RESET = INIT;
`else
  localparam mem_state_t ST_RESET = IDLE;
`endif
  mem_state_t     state, state_next;
  mem_op_t        op, op_next;
  logic           any_req, start, last;
  logic [TXW-1:0] tx;
  logic [5:0]     len;
  logic [DW-1:0]  rx_next;
  assign any_req = inst_fetch_req_in | data_read_req_in | data_write_req_in;
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) state <= ST_RESET;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE  ? (any_req ? SHIFT : IDLE) :
                 state == SHIFT ? (last ? DONE : SHIFT) :
                 state == DONE  ? IDLE : SHIFT;
`ifdef MEM_CTRL_SRAM_INIT_EN
    start = state == INIT || (state == IDLE && any_req);
`else
    start = state == IDLE && any_req;
`endif
    // Anything other than IDLE that starts a frame is the power-up WRMR
    op_next = state != IDLE       ? OP_INIT :
              inst_fetch_req_in   ? OP_FETCH :
              data_read_req_in    ? OP_READ : OP_WRITE;
    tx = op_next == OP_FETCH ? {SPI_CMD_READ, inst_addr_in, DW'(0)} :
         op_next == OP_READ  ? {SPI_CMD_READ, data_addr_in, DW'(0)} :
         op_next == OP_WRITE ? {SPI_CMD_WRITE, data_addr_in, DW'(wdata_in) << (DW - 8)} :
                               TXW'({SPI_CMD_WRMR, SPI_MODE_SEQ}) << (TXW - 16);
    len = op_next == OP_FETCH ? 6'(TXW - 1) :
          op_next == OP_INIT  ? 6'd15 : 6'(TXW - DW + 7);
  end
  always_comb begin
    mem_busy_out        = state != IDLE;
    spi_cs_n_out        = state != SHIFT;
    inst_fetch_done_out = state == DONE && op == OP_FETCH;
    data_read_done_out  = state == DONE && op == OP_READ;
  end
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      op        <= OP_FETCH;
      inst_out  <= '0;
      rdata_out <= '0;
    end else begin
      if (start) op <= op_next;
      if (last && op == OP_FETCH) inst_out <= rx_next;
      if (last && op == OP_READ) rdata_out <= rx_next[7:0];
    end
  spi_bit_engine #(.TXW(TXW), .RXW(DW)) u_engine (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .start      (start),
    .en         (state == SHIFT),
    .len        (len),
    .tx         (tx),
    .miso       (spi_miso_in),
    .sck        (spi_sck_out),
    .mosi       (spi_mosi_out),
    .last       (last),
    .rx_next    (rx_next)
  );
endmodule
